// File: rtl/modexp_pkg.sv
// Shared definitions for the modular-exponentiation controller: FSM state
// encoding and the default operand width.
package modexp_pkg;

  localparam int SIZE_DEFAULT = 64;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MUL_REQ  = 3'd1,
    ST_MUL_WAIT = 3'd2,
    ST_SQR_REQ  = 3'd3,
    ST_SQR_WAIT = 3'd4,
    ST_SHIFT    = 3'd5,
    ST_DONE     = 3'd6
  } state_e;

endpackage

// File: rtl/modexp_controller.sv
// Right-to-left binary modular exponentiation sequencer; products are
// computed by an external modular multiplier on the mm_* streams.
module modexp_controller
  import modexp_pkg::*;
#(
  parameter int SIZE  = SIZE_DEFAULT,
  parameter int CNT_W = $clog2(SIZE + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] cmd_base_tdata,
  input  logic [SIZE-1:0] cmd_exp_tdata,
  input  logic [SIZE-1:0] cmd_mod_tdata,
  input  logic            cmd_tvalid,
  output logic            cmd_tready,
  output logic [SIZE-1:0] res_tdata,
  output logic            res_err,
  output logic            res_tvalid,
  input  logic            res_tready,
  output logic [SIZE-1:0] mm_a_tdata,
  output logic [SIZE-1:0] mm_b_tdata,
  output logic [SIZE-1:0] mm_m_tdata,
  output logic            mm_in_tvalid,
  input  logic            mm_in_tready,
  input  logic [SIZE-1:0] mm_out_tdata,
  input  logic            mm_out_tvalid,
  output logic            mm_out_tready
);

  state_e           state_q, state_d;
  logic [SIZE-1:0]  acc_q, acc_d;
  logic [SIZE-1:0]  sq_q, sq_d;
  logic [SIZE-1:0]  e_q, e_d;
  logic [SIZE-1:0]  m_q, m_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Exponent bits above bit 0 still pending after the current step.
  logic e_more;
  assign e_more = |e_q[SIZE-1:1];

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    sq_d    = sq_q;
    e_d     = e_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_tvalid) begin
          acc_d = SIZE'(1);
          sq_d  = cmd_base_tdata;
          e_d   = cmd_exp_tdata;
          m_d   = cmd_mod_tdata;
          cnt_d = '0;
          err_d = 1'b0;
          if (cmd_mod_tdata == '0) begin
            acc_d   = '0;
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (cmd_mod_tdata == SIZE'(1)) begin
            acc_d   = '0;
            state_d = ST_DONE;
          end else if (cmd_exp_tdata == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = cmd_exp_tdata[0] ? ST_MUL_REQ : ST_SQR_REQ;
          end
        end
      end
      ST_MUL_REQ: if (mm_in_tready) state_d = ST_MUL_WAIT;
      ST_SQR_REQ: if (mm_in_tready) state_d = ST_SQR_WAIT;
      ST_MUL_WAIT: begin
        if (mm_out_tvalid) begin
          acc_d   = mm_out_tdata;
          state_d = e_more ? ST_SQR_REQ : ST_SHIFT;
        end
      end
      ST_SQR_WAIT: begin
        if (mm_out_tvalid) begin
          sq_d    = mm_out_tdata;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        e_d = e_q >> 1;
        if (cnt_q != CNT_W'(SIZE)) cnt_d = cnt_q + CNT_W'(1);
        if (!e_more)     state_d = ST_DONE;
        else if (e_q[1]) state_d = ST_MUL_REQ;
        else             state_d = ST_SQR_REQ;
      end
      ST_DONE: if (res_tready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      sq_q    <= '0;
      e_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sq_q    <= sq_d;
      e_q     <= e_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign cmd_tready    = (state_q == ST_IDLE);
  assign mm_in_tvalid  = (state_q == ST_MUL_REQ) || (state_q == ST_SQR_REQ);
  assign mm_out_tready = (state_q == ST_MUL_WAIT) || (state_q == ST_SQR_WAIT);
  assign mm_a_tdata    = (state_q == ST_MUL_REQ) ? acc_q : sq_q;
  assign mm_b_tdata    = sq_q;
  assign mm_m_tdata    = m_q;
  assign res_tvalid    = (state_q == ST_DONE);
  assign res_tdata     = acc_q;
  assign res_err       = err_q && (state_q == ST_DONE);

endmodule

// File: tb/tb_modexp_controller.sv
// Self-checking bench for modexp_controller: directed commands, a modular
// multiplier model with optional random stalls, and a result scoreboard.
module tb_modexp_controller;
  import modexp_pkg::*;

  localparam int SIZE    = SIZE_DEFAULT;
  localparam int TIMEOUT = 20000;
  localparam int MAX_LAT = 1 + SIZE * 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [SIZE-1:0] cmd_base_tdata = '0, cmd_exp_tdata = '0, cmd_mod_tdata = '0;
  logic            cmd_tvalid = 1'b0, cmd_tready;
  logic [SIZE-1:0] res_tdata;
  logic            res_err, res_tvalid;
  logic            res_tready = 1'b0;
  logic [SIZE-1:0] mm_a_tdata, mm_b_tdata, mm_m_tdata;
  logic            mm_in_tvalid;
  logic            mm_in_tready = 1'b0;
  logic [SIZE-1:0] mm_out_tdata = '0;
  logic            mm_out_tvalid = 1'b0, mm_out_tready;

  typedef struct {
    logic [SIZE-1:0] res;
    logic            err;
    int              reqs;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   req_cnt = 0;
  int   max_delay = 0;
  int   resp_force = -1;

  always #5 clk = ~clk;

  modexp_controller #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst),
    .cmd_base_tdata(cmd_base_tdata), .cmd_exp_tdata(cmd_exp_tdata),
    .cmd_mod_tdata(cmd_mod_tdata), .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready),
    .res_tdata(res_tdata), .res_err(res_err), .res_tvalid(res_tvalid), .res_tready(res_tready),
    .mm_a_tdata(mm_a_tdata), .mm_b_tdata(mm_b_tdata), .mm_m_tdata(mm_m_tdata),
    .mm_in_tvalid(mm_in_tvalid), .mm_in_tready(mm_in_tready),
    .mm_out_tdata(mm_out_tdata), .mm_out_tvalid(mm_out_tvalid), .mm_out_tready(mm_out_tready)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SIZE-1:0] mulmod(input logic [SIZE-1:0] a, b, m);
    logic [2*SIZE-1:0] p;
    p = {{SIZE{1'b0}}, a} * {{SIZE{1'b0}}, b};
    return SIZE'(p % {{SIZE{1'b0}}, m});
  endfunction

  // Left-to-right reference, independent of the controller's bit order.
  function automatic logic [SIZE-1:0] golden(input logic [SIZE-1:0] g, e, m);
    logic [SIZE-1:0] r;
    if (m <= SIZE'(1)) return '0;
    r = SIZE'(1);
    for (int i = SIZE - 1; i >= 0; i--) begin
      r = mulmod(r, r, m);
      if (e[i]) r = mulmod(r, g, m);
    end
    return r;
  endfunction

  function automatic int exp_reqs(input logic [SIZE-1:0] e, m);
    int pc, bl;
    if (m <= SIZE'(1) || e == '0) return 0;
    pc = 0;
    bl = 0;
    for (int i = 0; i < SIZE; i++) if (e[i]) begin pc++; bl = i + 1; end
    return pc + bl - 1;
  endfunction

  // Multiplier model: acts on negedges, so handshakes complete on the next posedge.
  logic [SIZE-1:0] ca, cb, cm;
  int   md, mn;
  bit   aborted;
  initial begin
    @(negedge clk);
    forever begin
      if (!(mm_in_tvalid === 1'b1 && !rst)) begin
        @(negedge clk);
      end else begin
        ca = mm_a_tdata;
        cb = mm_b_tdata;
        cm = mm_m_tdata;
        aborted = 1'b0;
        md = $urandom_range(max_delay, 0);
        for (int i = 0; i < md; i++) begin
          @(negedge clk);
          if (!rst) begin
            check("stall_in_valid", mm_in_tvalid, 1'b1);
            check("stall_a", mm_a_tdata, ca);
            check("stall_b", mm_b_tdata, cb);
            check("stall_m", mm_m_tdata, cm);
          end
        end
        mm_in_tready = 1'b1;
        req_cnt++;
        @(negedge clk);
        mm_in_tready = 1'b0;
        if (rst) aborted = 1'b1;
        md = (resp_force >= 0) ? resp_force : int'($urandom_range(max_delay, 0));
        for (int i = 0; i < md; i++) begin
          @(negedge clk);
          if (rst) aborted = 1'b1;
          if (!aborted) check("no_req_while_outstanding", mm_in_tvalid, 1'b0);
        end
        mm_out_tdata  = mulmod(ca, cb, cm);
        mm_out_tvalid = 1'b1;
        if (aborted) begin
          for (int i = 0; i < 3; i++) begin
            check("stray_resp_ignored", mm_out_tready, 1'b0);
            @(negedge clk);
          end
        end else begin
          mn = 0;
          while (!mm_out_tready && !rst && mn < TIMEOUT) begin
            @(negedge clk);
            mn++;
          end
          check("resp_accepted", mm_out_tready, 1'b1);
          if (mm_out_tready && !rst) @(negedge clk);
        end
        mm_out_tvalid = 1'b0;
      end
    end
  end

  task automatic drive_cmd(input logic [SIZE-1:0] g, e, m);
    int cyc;
    cyc = 0;
    while (!cmd_tready && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
    end
    check("cmd_ready_timeout", cmd_tready, 1'b1);
    req_cnt        = 0;
    cmd_base_tdata = g;
    cmd_exp_tdata  = e;
    cmd_mod_tdata  = m;
    cmd_tvalid     = 1'b1;
    @(negedge clk);
    cmd_tvalid     = 1'b0;
  endtask

  task automatic do_op(input logic [SIZE-1:0] g, e, m, input int hold, input bit chk_lat);
    exp_t x;
    int cyc;
    logic [SIZE-1:0] held;
    x.res  = golden(g, e, m);
    x.err  = (m == '0);
    x.reqs = exp_reqs(e, m);
    sb_q.push_back(x);
    drive_cmd(g, e, m);
    cyc = 1;
    while (!res_tvalid && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
    end
    check("res_timeout", res_tvalid, 1'b1);
    if (chk_lat) check("latency_bound", cyc <= MAX_LAT, 1'b1);
    held = res_tdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", res_tvalid, 1'b1);
      check("hold_data", res_tdata, held);
      check("hold_cmd_tready", cmd_tready, 1'b0);
    end
    x = sb_q.pop_front();
    res_tready = 1'b1;
    check("res_data", res_tdata, x.res);
    check("res_err", res_err, x.err);
    @(negedge clk);
    res_tready = 1'b0;
    check("req_count", req_cnt, x.reqs);
    check("idle_after_result", cmd_tready, 1'b1);
  endtask

  initial begin
    logic [SIZE-1:0] m61, ones, rg, rm, re;
    int cyc;
    m61  = (SIZE'(1) << 61) - SIZE'(1);
    ones = '1;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_cmd_tready", cmd_tready, 1'b1);
    check("rst_res_tvalid", res_tvalid, 1'b0);
    check("rst_res_err", res_err, 1'b0);
    check("rst_mm_in_tvalid", mm_in_tvalid, 1'b0);
    check("rst_mm_out_tready", mm_out_tready, 1'b0);

    max_delay = 0;
    do_op(SIZE'(4), SIZE'(13), SIZE'(497), 0, 1'b1);
    do_op(SIZE'(5), SIZE'(0), SIZE'(7), 0, 1'b1);
    do_op(SIZE'(3), SIZE'(9), SIZE'(1), 0, 1'b1);
    do_op(SIZE'(11), SIZE'(12345), SIZE'(0), 0, 1'b1);
    do_op(SIZE'(3), ones, m61, 0, 1'b1);

    max_delay = 5;
    do_op(SIZE'(2), ones, m61, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      rm = {$urandom, $urandom} | (SIZE'(1) << (SIZE - 1));
      rg = {$urandom, $urandom} % rm;
      re = {$urandom, $urandom};
      do_op(rg, re, rm, 0, 1'b0);
    end

    max_delay = 0;
    do_op(SIZE'(4), SIZE'(13), SIZE'(497), 10, 1'b0);

    // Abandon an operation while a square response is outstanding.
    resp_force = 6;
    drive_cmd(SIZE'(7), SIZE'(100), SIZE'(1009));
    cyc = 0;
    while (!mm_out_tready && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_sqr_wait", mm_out_tready, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    resp_force = -1;
    check("midop_rst_cmd_tready", cmd_tready, 1'b1);
    check("midop_rst_res_tvalid", res_tvalid, 1'b0);
    check("midop_rst_mm_in_tvalid", mm_in_tvalid, 1'b0);
    check("midop_rst_mm_out_tready", mm_out_tready, 1'b0);
    do_op(SIZE'(7), SIZE'(3), SIZE'(13), 0, 1'b0);

    repeat (5) @(negedge clk);
    check("no_extra_result", res_tvalid, 1'b0);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/modexp_controller.md
MODEXP_CONTROLLER -- requirements
Module: modexp_controller

Interface
REQ-001 SHALL have parameter SIZE, default 64, operand/modulus/result width in bits.
REQ-002 SHALL have parameter CNT_W, default $clog2(SIZE+1), bit-counter width.
REQ-003 clk  in  1  clock; all logic on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cmd_base_tdata  in  SIZE  base g; precondition g < modulus.
REQ-006 cmd_exp_tdata  in  SIZE  exponent e.
REQ-007 cmd_mod_tdata  in  SIZE  modulus m.
REQ-008 cmd_tvalid  in  1 / cmd_tready  out  1  command handshake.
REQ-009 res_tdata  out  SIZE  g^e mod m.
REQ-010 res_err  out  1  set with result when m == 0.
REQ-011 res_tvalid  out  1 / res_tready  in  1  result handshake.
REQ-012 mm_a_tdata, mm_b_tdata, mm_m_tdata  out  SIZE each  operands to external modular multiplier.
REQ-013 mm_in_tvalid  out  1 / mm_in_tready  in  1  multiplier request handshake.
REQ-014 mm_out_tdata  in  SIZE  (a*b) mod m from multiplier.
REQ-015 mm_out_tvalid  in  1 / mm_out_tready  out  1  multiplier response handshake.

Function
REQ-016 Algorithm SHALL be right-to-left binary: acc=1, sq=g, E=e; per step: if E[0] then acc=acc*sq mod m; if (E>>1)!=0 then sq=sq*sq mod m; E=E>>1; stop when E==0.
REQ-017 FSM states SHALL be IDLE, MUL_REQ, MUL_WAIT, SQR_REQ, SQR_WAIT, SHIFT, DONE.
REQ-018 IDLE: cmd_tready=1; on cmd_tvalid capture g,e,m into registers, acc=1, sq=g, E=e, step counter=0.
REQ-019 From IDLE on accept: m==0 -> DONE with res_tdata=0, res_err=1; m==1 -> DONE with 0, err=0; e==0 -> DONE with 1; else MUL_REQ if E[0]=1, SQR_REQ otherwise.
REQ-020 MUL_REQ: drive a=acc, b=sq, m, mm_in_tvalid=1; hold stable until mm_in_tready; then MUL_WAIT.
REQ-021 SQR_REQ: drive a=sq, b=sq; same handshake; then SQR_WAIT.
REQ-022 *_WAIT: mm_out_tready=1; on mm_out_tvalid load acc (MUL) or sq (SQR); MUL_WAIT -> SQR_REQ if (E>>1)!=0 else SHIFT; SQR_WAIT -> SHIFT.
REQ-023 SHIFT: E<=E>>1, counter++; if new E==0 -> DONE; else MUL_REQ if new E[0] else SQR_REQ.
REQ-024 DONE: res_tvalid=1, res_tdata=acc, stable until res_tready; then IDLE next cycle.
REQ-025 cmd_tready SHALL be 1 only in IDLE; one operation in flight; mm_in_tvalid never asserted while a response is outstanding.
REQ-026 mm_out_tvalid outside *_WAIT SHALL be ignored (mm_out_tready=0).
REQ-027 Counter SHALL saturate at SIZE; E reaching zero always terminates within SIZE SHIFTs.
REQ-028 Request count SHALL equal popcount(e) + bitlength(e) - 1 for e>0, m>1.
REQ-029 Command-to-DONE with zero-latency multiplier: at most 1 + SIZE*5 cycles.

Reset
REQ-030 rst SHALL force IDLE; cmd_tready=1 next cycle; res_tvalid, res_err, mm_in_tvalid, mm_out_tready=0; acc, sq, E, m, counter=0.
REQ-031 rst mid-operation SHALL abandon the operation with no result; a late mm_out_tvalid after reset SHALL be ignored.

Structure
REQ-032 Package modexp_pkg SHALL hold the state enum and default SIZE constant.
REQ-033 No sub-module; the modular multiplier is external, attached through mm_* ports; bench supplies a model.

Verification
REQ-034 g=4, e=13, m=497 -> res_tdata=445, err=0; exactly 6 multiplier requests.
REQ-035 g=5, e=0, m=7 -> res 1 with no multiplier request; g=3, e=9, m=1 -> res 0.
REQ-036 m=0, any g,e -> res_err=1, res_tdata=0, no multiplier request.
REQ-037 g=2, e=2^64-1, m=2^61-1, multiplier with random 0-5 cycle ready/valid delays -> res equals golden model; operands stable while stalled.
REQ-038 rst asserted during SQR_WAIT of g=7,e=100,m=1009, then new command g=7,e=3,m=13 -> first result never emitted; second res=5; stray mm_out_tvalid ignored.
REQ-039 res_tready held 0 for 10 cycles after DONE -> res_tvalid/res_tdata stable, cmd_tready=0 throughout.
